// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the byte-enable generator and the data memory port.
// Optional tail-merge of same-word stores: define STORE_WRITE_BUFFER_COALESCE_EN.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_store_valid,
  input  logic [31:0]      i_store_addr,
  input  logic [31:0]      i_store_data,
  input  logic [3:0]       i_byte_enable,
  output logic             o_store_ready,
  output logic             o_mem_valid,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic [3:0]       o_mem_be,
  input  logic             i_mem_ready,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CNT_W-1:0] count_q;

  logic        has_data;
  logic        push;
  logic        pop;
  logic        merge_hit;
  logic [31:0] in_mask;
  logic        unused_ok;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  assign unused_ok = ^i_store_addr[1:0];
  assign in_mask   = lane_mask(i_byte_enable);
  assign has_data  = count_q != '0;

`ifdef STORE_WRITE_BUFFER_COALESCE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr  = wr_ptr - PW'(1);
  // Tail is never the presented head once two or more entries are held.
  assign merge_hit = i_store_valid && (i_byte_enable != 4'b0000)
                  && (count_q >= CNT_W'(2))
                  && (addr_q[tail_ptr] == i_store_addr[31:2]);
`else
  assign merge_hit = 1'b0;
`endif

  assign o_store_ready = (count_q < FULL) || merge_hit;
  assign push = i_store_valid && o_store_ready
             && (i_byte_enable != 4'b0000) && !merge_hit;
  assign pop  = has_data && i_mem_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_q[wr_ptr] <= i_store_addr[31:2];
      data_q[wr_ptr] <= i_store_data & in_mask;
      be_q[wr_ptr]   <= i_byte_enable;
    end
`ifdef STORE_WRITE_BUFFER_COALESCE_EN
    if (merge_hit) begin
      data_q[tail_ptr] <= (data_q[tail_ptr] & ~in_mask)
                        | (i_store_data & in_mask);
      be_q[tail_ptr]   <= be_q[tail_ptr] | i_byte_enable;
    end
`endif
  end

  assign o_mem_valid = has_data;
  assign o_empty     = !has_data;
  assign o_count     = count_q;
  assign o_mem_addr  = has_data ? {addr_q[rd_ptr], 2'b00} : '0;
  assign o_mem_wdata = has_data ? data_q[rd_ptr] : '0;
  assign o_mem_be    = has_data ? be_q[rd_ptr] : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized bench for store_write_buffer against a queue-based model.
// Directed scenarios first, then a long random run with resets.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             store_valid = 1'b0;
  logic [31:0]      store_addr = '0;
  logic [31:0]      store_data = '0;
  logic [3:0]       byte_enable = '0;
  logic             store_ready;
  logic             mem_valid;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_ready = 1'b0;
  logic             empty;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_store_valid(store_valid),
    .i_store_addr (store_addr),
    .i_store_data (store_data),
    .i_byte_enable(byte_enable),
    .o_store_ready(store_ready),
    .o_mem_valid  (mem_valid),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_be     (mem_be),
    .i_mem_ready  (mem_ready),
    .o_empty      (empty),
    .o_count      (count)
  );

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  bit   known = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] keep(input logic [31:0] d,
                                       input logic [3:0] be);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic mr, input logic rn);
    bit   rdy, mg, pu, po;
    ent_t e;
    store_valid = v; store_addr = a; store_data = d;
    byte_enable = be; mem_ready = mr; rst_n = rn;
    @(negedge clk);
    mg = 0;
`ifdef STORE_WRITE_BUFFER_COALESCE_EN
    if (v && be != 0 && q.size() >= 2 && q[$].a == a[31:2]) mg = 1;
`endif
    rdy = (q.size() < DEPTH) || mg;
    pu  = v && rdy && be != 0 && !mg;
    po  = q.size() > 0 && mr;
    if (known) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("valid", 32'(mem_valid), 32'(q.size() != 0));
      chk("ready", 32'(store_ready), 32'(rdy));
      if (q.size() != 0) begin
        chk("addr", mem_addr, {q[0].a, 2'b00});
        chk("wdata", mem_wdata, q[0].d);
        chk("be", 32'(mem_be), 32'(q[0].be));
      end else begin
        chk("addr0", mem_addr, 32'h0);
        chk("wdata0", mem_wdata, 32'h0);
        chk("be0", 32'(mem_be), 32'h0);
      end
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      q.delete();
      known = 1;
    end else if (known) begin
      if (mg) begin
        q[$].d  = keep(q[$].d, ~be) | keep(d, be);
        q[$].be = q[$].be | be;
      end
      if (po) void'(q.pop_front());
      if (pu) begin
        e.a = a[31:2]; e.d = keep(d, be); e.be = be;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic mr);
    step(1'b0, '0, '0, 4'b0000, mr, 1'b1);
  endtask

  logic [3:0] be_tab [8];

  initial begin
    logic [3:0]  be;
    logic [31:0] a;
    be_tab[0] = 4'b0001; be_tab[1] = 4'b0010; be_tab[2] = 4'b0100;
    be_tab[3] = 4'b1000; be_tab[4] = 4'b0011; be_tab[5] = 4'b1100;
    be_tab[6] = 4'b1111; be_tab[7] = 4'b0000;

    step(1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
    step(1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
    // single byte store, immediately drained
    step(1'b1, 32'h102, 32'h00AB0000, 4'b0100, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    // fill to full with a fifth store held, then drain
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h1000 + 32'(i) * 4, 32'hA0 + 32'(i), 4'b1111,
           1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h1010, 32'hA4, 4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    // zero-enable no-op
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h300, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1);
    // streaming push and pop across pointer wrap
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h2000 + 32'(i) * 4, $urandom, 4'b1111, 1'b1, 1'b1);
    idle(1'b1);
    // reset mid-drain
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h400 + 32'(i) * 4, $urandom, 4'b1111, 1'b0, 1'b1);
    step(1'b0, '0, '0, 4'b0000, 1'b1, 1'b0);
    idle(1'b0);
    // same-word stores behind a different head
    step(1'b1, 32'h200, 32'h11111111, 4'b1111, 1'b0, 1'b1);
    step(1'b1, 32'h204, 32'h00002222, 4'b0011, 1'b0, 1'b1);
    step(1'b1, 32'h207, 32'h33000000, 4'b1000, 1'b0, 1'b1);
    idle(1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    for (int n = 0; n < 3000; n++) begin
      be = be_tab[$urandom_range(0, 7)];
      a  = 32'h200 | (32'($urandom_range(0, 3)) << 2)
         | 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, a, $urandom, be,
           (n / 200) % 2 == 0 ? $urandom_range(0, 3) == 0
                              : $urandom_range(0, 3) != 0,
           $urandom_range(0, 149) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
